// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Initiator side of the single-cycle data-memory interface.
//                Turns byte-addressed load/store requests into word-indexed
//                memory strobes. Loads are lane-selected and extended.
//                Sub-word stores run as read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] c_s_idle     = 3'd0;
    localparam logic [2:0] c_s_load     = 3'd1;
    localparam logic [2:0] c_s_rmw_read = 3'd2;
    localparam logic [2:0] c_s_store    = 3'd3;
    localparam logic [2:0] c_s_resp     = 3'd4;

    localparam logic [29:0] c_depth_words = 30'(DEPTH);

    logic [2:0]  state_q,  state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] merge_q,  merge_d;   // store data on accept, full write word after RMW
    logic [31:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic        w_funct3_ok;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_rmw_word;

    // Request legality check, evaluated on the live request inputs in IDLE
    always_comb begin
        if (req_write) begin
            w_funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                          (req_funct3 == 3'b010);
        end else begin
            w_funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                          (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                          (req_funct3 == 3'b101);
        end
        // Low two funct3 bits give the access size once funct3 is known legal
        w_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_out_of_range = (req_addr[31:2] >= c_depth_words);
        w_req_err      = !w_funct3_ok || w_misaligned || w_out_of_range;
    end

    // Load lane selection and sign/zero extension of the memory word
    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'h0, w_byte};
            3'b101:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // Sub-word store merge: current memory word with the addressed lane replaced
    always_comb begin
        w_rmw_word = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            unique case (addr_q[1:0])
                2'b00:   w_rmw_word[7:0]   = merge_q[7:0];
                2'b01:   w_rmw_word[15:8]  = merge_q[7:0];
                2'b10:   w_rmw_word[23:16] = merge_q[7:0];
                default: w_rmw_word[31:24] = merge_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            w_rmw_word[31:16] = merge_q[15:0];
        end else begin
            w_rmw_word[15:0]  = merge_q[15:0];
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_s_idle;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            c_s_idle: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    merge_d  = req_wdata;
                    rdata_d  = 32'h0;
                    if (w_req_err) begin
                        err_d   = 1'b1;
                        state_d = c_s_resp;
                    end else if (!req_write) begin
                        state_d = c_s_load;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = c_s_store;
                    end else begin
                        state_d = c_s_rmw_read;
                    end
                end
            end
            c_s_load: begin
                rdata_d = w_load_ext;
                state_d = c_s_resp;
            end
            c_s_rmw_read: begin
                merge_d = w_rmw_word;
                state_d = c_s_store;
            end
            c_s_store: begin
                state_d = c_s_resp;
            end
            c_s_resp: begin
                if (rsp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = c_s_idle;
                end
            end
            default: begin
                state_d = c_s_idle;
            end
        endcase
    end

    // Outputs decoded purely from the state register so reset drops them at once
    always_comb begin
        req_ready = (state_q == c_s_idle);
        busy      = (state_q != c_s_idle);
        rsp_valid = (state_q == c_s_resp);
        mem_read  = (state_q == c_s_load) || (state_q == c_s_rmw_read);
        mem_write = (state_q == c_s_store);
        mem_addr  = (mem_read || mem_write) ? {2'b00, addr_q[31:2]} : 32'h0;
        mem_wdata = mem_write ? merge_q : 32'h0;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a 64-word
//                combinational-read memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63] = '{default: 32'h0};

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write && (mem_addr < 32'd64)) mem[mem_addr[5:0]] <= mem_wdata;
    end

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        logic        saw_rd, saw_wr;
        logic [31:0] wa, wd;
        saw_rd = 1'b0; saw_wr = 1'b0; wa = 32'h0; wd = 32'h0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = v.write;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        chk($sformatf("v%0d req_ready", idx), {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 32'h5A5A5A5A;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            if (mem_read)  saw_rd = 1'b1;
            if (mem_write) begin saw_wr = 1'b1; wa = mem_addr; wd = mem_wdata; end
            if (mem_read && mem_write) chk($sformatf("v%0d rd_wr_excl", idx), 32'h1, 32'h0);
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d rsp_err", idx), {31'h0, rsp_err}, {31'h0, v.exp_err});
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        if (v.exp_err) begin
            chk($sformatf("v%0d no_mem_access", idx), {30'h0, saw_rd, saw_wr}, 32'h0);
        end else if (v.write) begin
            chk($sformatf("v%0d wr_seen", idx), {31'h0, saw_wr}, 32'h1);
            chk($sformatf("v%0d mem_addr", idx), wa, v.exp_maddr);
            chk($sformatf("v%0d mem_wdata", idx), wd, v.exp_mwdata);
        end else begin
            chk($sformatf("v%0d rd_seen", idx), {31'h0, saw_rd}, 32'h1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk($sformatf("v%0d post_valid", idx), {31'h0, rsp_valid}, 32'h0);
        chk($sformatf("v%0d post_clear", idx), {rsp_rdata[30:0], rsp_err}, 32'h0);
        chk($sformatf("v%0d post_ready", idx), {31'h0, req_ready}, 32'h1);
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] er, input logic ee,
                                input int el, input logic [31:0] ma, input logic [31:0] mw);
        vec_t v;
        v.write = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = er;
        v.exp_err = ee; v.exp_lat = el; v.exp_maddr = ma; v.exp_mwdata = mw;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 32'd4,  32'hDEADBEEF);
        vecs[1]  = mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 32'd0,  32'h0);
        vecs[2]  = mk(1, 3'b010, 32'h10,  32'h11223344, 32'h0,        0, 2, 32'd4,  32'h11223344);
        vecs[3]  = mk(1, 3'b000, 32'h13,  32'h000000AA, 32'h0,        0, 3, 32'd4,  32'hAA223344);
        vecs[4]  = mk(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFAA, 0, 2, 32'd0,  32'h0);
        vecs[5]  = mk(0, 3'b100, 32'h13,  32'h0,        32'h000000AA, 0, 2, 32'd0,  32'h0);
        vecs[6]  = mk(1, 3'b001, 32'h12,  32'h00008001, 32'h0,        0, 3, 32'd4,  32'h80013344);
        vecs[7]  = mk(0, 3'b001, 32'h12,  32'h0,        32'hFFFF8001, 0, 2, 32'd0,  32'h0);
        vecs[8]  = mk(0, 3'b101, 32'h12,  32'h0,        32'h00008001, 0, 2, 32'd0,  32'h0);
        vecs[9]  = mk(0, 3'b101, 32'h10,  32'h0,        32'h00003344, 0, 2, 32'd0,  32'h0);
        vecs[10] = mk(0, 3'b000, 32'h11,  32'h0,        32'h00000033, 0, 2, 32'd0,  32'h0);
        vecs[11] = mk(0, 3'b000, 32'h12,  32'h0,        32'h00000001, 0, 2, 32'd0,  32'h0);
        vecs[12] = mk(0, 3'b010, 32'h11,  32'h0,        32'h0,        1, 1, 32'd0,  32'h0);
        vecs[13] = mk(0, 3'b010, 32'h100, 32'h0,        32'h0,        1, 1, 32'd0,  32'h0);
        vecs[14] = mk(0, 3'b011, 32'h0,   32'h0,        32'h0,        1, 1, 32'd0,  32'h0);
        vecs[15] = mk(1, 3'b100, 32'h0,   32'h12,       32'h0,        1, 1, 32'd0,  32'h0);
        vecs[16] = mk(0, 3'b001, 32'h13,  32'h0,        32'h0,        1, 1, 32'd0,  32'h0);
        vecs[17] = mk(1, 3'b010, 32'hFC,  32'h12345678, 32'h0,        0, 2, 32'd63, 32'h12345678);
        vecs[18] = mk(0, 3'b010, 32'hFC,  32'h0,        32'h12345678, 0, 2, 32'd0,  32'h0);
        vecs[19] = mk(1, 3'b001, 32'h11,  32'h1234,     32'h0,        1, 1, 32'd0,  32'h0);
        vecs[20] = mk(1, 3'b001, 32'hFE,  32'h0000BEEF, 32'h0,        0, 3, 32'd63, 32'hBEEF5678);
        vecs[21] = mk(0, 3'b001, 32'hFE,  32'h0,        32'hFFFFBEEF, 0, 2, 32'd0,  32'h0);
        vecs[22] = mk(1, 3'b000, 32'h10,  32'hFFFFFF55, 32'h0,        0, 3, 32'd4,  32'h80013355);
        vecs[23] = mk(0, 3'b010, 32'h10,  32'h0,        32'h80013355, 0, 2, 32'd0,  32'h0);

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        #12;
        chk("reset req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset flags", {27'h0, rsp_valid, rsp_err, mem_read, mem_write, busy}, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Response stall: rsp_ready low for 5 cycles, stray request ignored
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d rsp_valid", c), {31'h0, rsp_valid}, 32'h1);
            chk($sformatf("stall%0d rsp_rdata", c), rsp_rdata, 32'h80013355);
            chk($sformatf("stall%0d req_ready", c), {31'h0, req_ready}, 32'h0);
            @(negedge clk);
            req_valid = (c == 1);
            req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall idle busy", {31'h0, busy}, 32'h0);
        chk("stall no rsp", {31'h0, rsp_valid}, 32'h0);
        run_vec(100, mk(0, 3'b010, 32'h10, 32'h0, 32'h80013355, 0, 2, 32'd0, 32'h0));

        // Reset in the middle of a SW
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst store mem_write", {31'h0, mem_write}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst flags", {28'h0, rsp_valid, rsp_err, mem_read, busy}, 32'h0);
        chk("rst req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst outputs", mem_addr | mem_wdata | rsp_rdata, 32'h0);
        @(posedge clk); #1;
        chk("rst held mem_write", {31'h0, mem_write}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst word8", mem[8], 32'h0);
        run_vec(101, mk(0, 3'b010, 32'h20, 32'h0, 32'h0, 0, 2, 32'd0, 32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
